// File: rtl/logic_axi4_stream_transfer_counter_multi.sv
// rtl/logic_axi4_stream_transfer_counter_multi.sv - multi-channel AXI4-Stream beat/packet/byte counter with snapshot report stream
// Optional feature macro: LOGIC_AXI4_STREAM_TRANSFER_COUNTER_MULTI_SATURATE_EN (defined: saturating counters, undefined: wrapping counters)
module logic_axi4_stream_transfer_counter_multi #(
    parameter int CHANNELS      = 4,
    parameter int MODE          = 0,
    parameter int TDATA_BYTES   = 4,
    parameter int COUNTER_WIDTH = 32,
    parameter int REPORT_PERIOD = 0,
    localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        snapshot,
    input  logic [CHANNELS-1:0]         monitor_tvalid,
    input  logic [CHANNELS-1:0]         monitor_tready,
    input  logic [CHANNELS-1:0]         monitor_tlast,
    input  logic [CHANNELS*TDATA_BYTES-1:0] monitor_tkeep,
    output logic                        tx_tvalid,
    input  logic                        tx_tready,
    output logic                        tx_tlast,
    output logic [TDATA_BYTES*8-1:0]    tx_tdata,
    output logic [CH_W-1:0]             tx_tid,
    output logic                        tx_tuser
);

    localparam int TDATA_W = TDATA_BYTES * 8;
    localparam int INC_W   = $clog2(TDATA_BYTES + 1);
    localparam int SUM_W   = ((COUNTER_WIDTH > INC_W) ? COUNTER_WIDTH : INC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({COUNTER_WIDTH{1'b1}});

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [COUNTER_WIDTH-1:0]   r_count  [CHANNELS];
    logic [COUNTER_WIDTH-1:0]   r_shadow [CHANNELS];
    logic [INC_W-1:0]           w_inc    [CHANNELS];
    logic [CH_W-1:0]            r_idx;
    logic [CH_W-1:0]            w_idx_inc;
    logic                       r_overrun;
    logic                       r_tx_tvalid;
    logic                       r_tx_tlast;
    logic [TDATA_W-1:0]         r_tx_tdata;
    logic [CH_W-1:0]            r_tx_tid;
    logic                       r_tx_tuser;
    logic                       w_timer_fire;
    logic                       w_trigger;
    logic                       w_accept;
    logic                       w_hs;
    logic                       w_last_beat;

    // Counter add with either saturation or modulo wrap; the sum is one bit wider so a crossing is visible
    function automatic logic [COUNTER_WIDTH-1:0] f_add(input logic [COUNTER_WIDTH-1:0] base,
                                                       input logic [INC_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(inc);
`ifdef LOGIC_AXI4_STREAM_TRANSFER_COUNTER_MULTI_SATURATE_EN
        if (sum > CNT_MAX) begin
            f_add = {COUNTER_WIDTH{1'b1}};
        end else begin
            f_add = sum[COUNTER_WIDTH-1:0];
        end
`else
        f_add = sum[COUNTER_WIDTH-1:0];
`endif
        return f_add;
    endfunction

    // Per-channel increment for this cycle, selected by the counting mode
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            logic [INC_W-1:0] pop;
            logic             hs;
            pop = '0;
            for (int b = 0; b < TDATA_BYTES; b++) begin
                pop = pop + INC_W'(monitor_tkeep[i*TDATA_BYTES + b]);
            end
            hs = monitor_tvalid[i] & monitor_tready[i];
            w_inc[i] = '0;
            if (hs) begin
                if (MODE == 1) begin
                    w_inc[i] = INC_W'(monitor_tlast[i]);
                end else if (MODE == 2) begin
                    w_inc[i] = pop;
                end else begin
                    w_inc[i] = INC_W'(1);
                end
            end
        end
    end

    generate
        if (REPORT_PERIOD > 0) begin : g_timer
            localparam int TW = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
            logic [TW-1:0] r_timer;

            // Free-running period timer, independent of report activity
            always_ff @(posedge aclk) begin
                if (areset) begin
                    r_timer <= '0;
                end else if (r_timer == TW'(REPORT_PERIOD - 1)) begin
                    r_timer <= '0;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end

            assign w_timer_fire = (r_timer == TW'(REPORT_PERIOD - 1));
        end else begin : g_no_timer
            assign w_timer_fire = 1'b0;
        end
    endgenerate

    assign w_trigger   = snapshot | w_timer_fire;
    assign w_accept    = (r_state == S_IDLE) & w_trigger;
    assign w_hs        = r_tx_tvalid & tx_tready;
    assign w_last_beat = (r_idx == CH_W'(CHANNELS - 1));
    assign w_idx_inc   = r_idx + 1'b1;

    // FSM state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: one report per accepted trigger, ending on the last-beat handshake
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_hs && w_last_beat) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Live counters; on an accepted trigger they restart from this cycle's increment so no beat is lost
    always_ff @(posedge aclk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (areset) begin
                r_count[i] <= '0;
            end else if (w_accept) begin
                r_count[i] <= f_add('0, w_inc[i]);
            end else begin
                r_count[i] <= f_add(r_count[i], w_inc[i]);
            end
        end
    end

    // Shadow copy of the counters, frozen for the whole report
    always_ff @(posedge aclk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (areset) begin
                r_shadow[i] <= '0;
            end else if (w_accept) begin
                r_shadow[i] <= r_count[i];
            end
        end
    end

    // Sticky overrun: a trigger arriving while a report is still being sent is dropped and remembered
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_overrun <= 1'b0;
        end else if (w_accept) begin
            r_overrun <= 1'b0;
        end else if (w_trigger) begin
            r_overrun <= 1'b1;
        end
    end

    // Beat index and registered report outputs; the next beat is loaded only on a handshake
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_idx       <= '0;
            r_tx_tvalid <= 1'b0;
            r_tx_tlast  <= 1'b0;
            r_tx_tdata  <= '0;
            r_tx_tid    <= '0;
            r_tx_tuser  <= 1'b0;
        end else if (w_accept) begin
            r_idx       <= '0;
            r_tx_tvalid <= 1'b1;
            r_tx_tlast  <= (CHANNELS == 1);
            r_tx_tdata  <= TDATA_W'(r_count[0]);
            r_tx_tid    <= '0;
            r_tx_tuser  <= r_overrun;
        end else if (w_hs) begin
            if (w_last_beat) begin
                r_tx_tvalid <= 1'b0;
                r_tx_tlast  <= 1'b0;
            end else begin
                r_idx       <= w_idx_inc;
                r_tx_tdata  <= TDATA_W'(r_shadow[w_idx_inc]);
                r_tx_tid    <= w_idx_inc;
                r_tx_tlast  <= (w_idx_inc == CH_W'(CHANNELS - 1));
            end
        end
    end

    assign tx_tvalid = r_tx_tvalid;
    assign tx_tlast  = r_tx_tlast;
    assign tx_tdata  = r_tx_tdata;
    assign tx_tid    = r_tx_tid;
    assign tx_tuser  = r_tx_tuser;

endmodule

// File: tb/tb_logic_axi4_stream_transfer_counter_multi.sv
// tb/tb_logic_axi4_stream_transfer_counter_multi.sv - randomized self-checking bench for the multi-channel transfer counter
module tb_logic_axi4_stream_transfer_counter_multi;

    localparam int NI = 4;
    localparam int CH = 4;
    localparam int TB = 4;
    localparam int MODE_T [NI] = '{0, 1, 2, 0};
    localparam int CW_T   [NI] = '{32, 32, 4, 32};
    localparam int PER_T  [NI] = '{0, 0, 0, 16};
    localparam int N_CYC  = 4000;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic                 areset;
    logic                 snapshot;
    logic [CH-1:0]        m_tvalid;
    logic [CH-1:0]        m_tready;
    logic [CH-1:0]        m_tlast;
    logic [CH*TB-1:0]     m_tkeep;
    logic [NI-1:0]        tx_tready;
    logic [NI-1:0]        tx_tvalid;
    logic [NI-1:0]        tx_tlast;
    logic [NI-1:0]        tx_tuser;
    logic [TB*8-1:0]      tx_tdata [NI];
    logic [1:0]           tx_tid   [NI];

    generate
        for (genvar k = 0; k < NI; k++) begin : g_dut
            logic w_snap;
            assign w_snap = (PER_T[k] > 0) ? 1'b0 : snapshot;
            logic_axi4_stream_transfer_counter_multi #(
                .CHANNELS      (CH),
                .MODE          (MODE_T[k]),
                .TDATA_BYTES   (TB),
                .COUNTER_WIDTH (CW_T[k]),
                .REPORT_PERIOD (PER_T[k])
            ) u_dut (
                .aclk           (aclk),
                .areset         (areset),
                .snapshot       (w_snap),
                .monitor_tvalid (m_tvalid),
                .monitor_tready (m_tready),
                .monitor_tlast  (m_tlast),
                .monitor_tkeep  (m_tkeep),
                .tx_tvalid      (tx_tvalid[k]),
                .tx_tready      (tx_tready[k]),
                .tx_tlast       (tx_tlast[k]),
                .tx_tdata       (tx_tdata[k]),
                .tx_tid         (tx_tid[k]),
                .tx_tuser       (tx_tuser[k])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mathematical counts, the pending report as a list of beats, sticky overrun, cycles since reset
    longint cnt      [NI][CH];
    longint rep      [NI][CH];
    bit     rep_user [NI];
    bit     ovr      [NI];
    int     rem      [NI];
    int     tcyc     [NI];
    int     run_len  [NI];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint lim_add(input int k, input longint a, input longint b);
        longint mx;
        longint s;
        mx = (longint'(1) << CW_T[k]) - 1;
        s  = a + b;
`ifdef LOGIC_AXI4_STREAM_TRANSFER_COUNTER_MULTI_SATURATE_EN
        return (s > mx) ? mx : s;
`else
        return s % (mx + 1);
`endif
    endfunction

    function automatic longint beat_inc(input int k, input int i);
        logic [TB-1:0] keep;
        keep = m_tkeep[i*TB +: TB];
        if (!(m_tvalid[i] && m_tready[i])) return 0;
        if (MODE_T[k] == 1) return longint'(m_tlast[i]);
        if (MODE_T[k] == 2) return longint'($countones(keep));
        return 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < CH; i++) begin
                cnt[k][i] = 0;
                rep[k][i] = 0;
            end
            rep_user[k] = 0;
            ovr[k]      = 0;
            rem[k]      = 0;
            tcyc[k]     = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            bit busy;
            bit trig;
            busy = (rem[k] > 0);
            trig = (PER_T[k] > 0) ? ((tcyc[k] % PER_T[k]) == PER_T[k] - 1) : snapshot;
            if (busy && tx_tready[k]) rem[k]--;
            if (trig && !busy) begin
                for (int i = 0; i < CH; i++) begin
                    rep[k][i] = cnt[k][i];
                    cnt[k][i] = lim_add(k, 0, beat_inc(k, i));
                end
                rep_user[k] = ovr[k];
                ovr[k]      = 0;
                rem[k]      = CH;
            end else begin
                if (trig) ovr[k] = 1;
                for (int i = 0; i < CH; i++) cnt[k][i] = lim_add(k, cnt[k][i], beat_inc(k, i));
            end
            tcyc[k]++;
        end
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("u%0d_rst_tvalid", k), tx_tvalid[k], 0);
            check($sformatf("u%0d_rst_tlast", k), tx_tlast[k], 0);
            check($sformatf("u%0d_rst_tdata", k), tx_tdata[k], 0);
            check($sformatf("u%0d_rst_tid", k), tx_tid[k], 0);
            check($sformatf("u%0d_rst_tuser", k), tx_tuser[k], 0);
        end
    endtask

    task automatic check_outputs(input int cyc);
        for (int k = 0; k < NI; k++) begin
            int b;
            check($sformatf("u%0d_tvalid_c%0d", k, cyc), tx_tvalid[k], (rem[k] > 0) ? 1 : 0);
            if (rem[k] > 0) begin
                b = CH - rem[k];
                check($sformatf("u%0d_tdata_c%0d_b%0d", k, cyc, b), tx_tdata[k], rep[k][b]);
                check($sformatf("u%0d_tid_c%0d", k, cyc), tx_tid[k], b);
                check($sformatf("u%0d_tlast_c%0d", k, cyc), tx_tlast[k], (b == CH - 1) ? 1 : 0);
                check($sformatf("u%0d_tuser_c%0d", k, cyc), tx_tuser[k], rep_user[k]);
            end
        end
    endtask

    task automatic drive_random();
        m_tvalid = CH'($urandom);
        m_tready = CH'($urandom | $urandom);
        m_tlast  = CH'($urandom);
        m_tkeep  = (CH*TB)'($urandom);
        snapshot = ($urandom_range(0, 19) == 0);
        for (int k = 0; k < NI; k++) begin
            if (run_len[k] == 0) begin
                tx_tready[k] = ($urandom_range(0, 3) != 0);
                run_len[k]   = $urandom_range(1, 14);
            end else begin
                run_len[k]--;
            end
        end
    endtask

    initial begin
        bit rst_done;
        bit was_reset;
        areset    = 1'b1;
        snapshot  = 1'b0;
        m_tvalid  = '0;
        m_tready  = '0;
        m_tlast   = '0;
        m_tkeep   = '0;
        tx_tready = '0;
        for (int k = 0; k < NI; k++) run_len[k] = 0;
        rst_done  = 0;
        was_reset = 1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        model_reset();

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            if (was_reset) check_reset_state();
            else check_outputs(cyc);
            drive_random();
            areset = ($urandom_range(0, 799) == 0);
            if (!rst_done && cyc > 2000 && rem[3] == CH - 1) begin
                areset   = 1'b1;
                rst_done = 1;
            end
            if (areset) model_reset();
            else model_step();
            was_reset = areset;
            @(negedge aclk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_axi4_stream_transfer_counter_multi.md
Name: logic_axi4_stream_transfer_counter_multi

Overview:
Multi-channel, multi-mode successor to the single-pair AXI4-Stream transfer counter. Passively monitors CHANNELS AXI4-Stream interfaces and counts beats, packets or bytes per channel. On a snapshot trigger (external pulse or internal periodic timer), all counters are latched and cleared atomically. The latched values are sent as one report packet, one beat per channel, on an AXI4-Stream Tx port. Used for throughput and statistics collection.

Parameters:
CHANNELS, 4, number of monitored interfaces (>=1)
MODE, 0, 0=count beats, 1=count packets (tlast beats), 2=count bytes (popcount of tkeep)
TDATA_BYTES, 4, monitored tkeep width and report tdata byte width
COUNTER_WIDTH, 32, per-channel counter width; must be <= TDATA_BYTES*8
REPORT_PERIOD, 0, auto-trigger period in cycles; 0 disables the timer

Ports:
aclk  input  1  clock; all logic on rising edge
areset  input  1  synchronous, active-high reset
snapshot  input  1  single-cycle trigger request
monitor_tvalid  input  CHANNELS  per-channel tvalid
monitor_tready  input  CHANNELS  per-channel tready
monitor_tlast  input  CHANNELS  per-channel tlast
monitor_tkeep  input  CHANNELS*TDATA_BYTES  per-channel tkeep; channel i at [i*TDATA_BYTES +: TDATA_BYTES]
tx_tvalid  output  1  report beat valid
tx_tready  input  1  report beat ready
tx_tlast  output  1  last beat of report
tx_tdata  output  TDATA_BYTES*8  counter value, zero-extended
tx_tid  output  CH_W  channel index of beat; CH_W = CHANNELS>1 ? $clog2(CHANNELS) : 1
tx_tuser  output  1  overrun flag for this report

Behaviour:
- Reset, sampled at the aclk edge while areset=1: counters, shadow registers, timer and overrun flag are 0; FSM is IDLE; tx_tvalid, tx_tlast, tx_tdata, tx_tid and tx_tuser are 0.
- Reset asserted mid-report abandons the report. tx_tvalid goes 0 at the next edge regardless of tx_tready. This is accepted.
- Per-channel increment in a cycle where tvalid&tready=1:
  - MODE0: +1.
  - MODE1: +1 only when tlast=1.
  - MODE2: +popcount(tkeep); 0 when tkeep=0.
  - No increment when tvalid&tready=0.
- Arithmetic is COUNTER_WIDTH bits. Overflow handling is governed by the Optional Feature.
- Timer (REPORT_PERIOD>0): free-running 0..REPORT_PERIOD-1. timer_fire=1 in the cycle the value is REPORT_PERIOD-1, then wraps to 0. The timer runs even while a report is in progress.
- trigger = snapshot | timer_fire. Simultaneous snapshot and timer_fire count as one trigger.
- FSM IDLE:
  - tx_tvalid=0.
  - On trigger, at the next edge:
    - shadow[i] <= counter[i] (value before this cycle's increment)
    - counter[i] <= this cycle's increment (0 if none), so no transfer is lost or double-counted
    - report_overrun <= overrun; overrun <= 0
    - idx <= 0
    - state <= SEND
- FSM SEND:
  - tx_tvalid=1; tx_tdata=shadow[idx]; tx_tid=idx; tx_tuser=report_overrun; tx_tlast=(idx==CHANNELS-1).
  - On tx_tvalid&tx_tready: if idx<CHANNELS-1 then idx+1, else state <= IDLE.
  - tx outputs are registered and hold stable while tx_tvalid=1 and tx_tready=0.
  - CHANNELS=1 gives a single beat with tlast=1.
- Trigger while in SEND, including the cycle of the last-beat handshake:
  - The trigger is dropped and counters are not cleared.
  - overrun <= 1 (sticky until the next accepted trigger).
- Latency: trigger at cycle N gives first tx_tvalid at N+1. Back-to-back triggers need an IDLE cycle between reports.
- Shadow registers never change during SEND.

Optional Feature:
Macro LOGIC_AXI4_STREAM_TRANSFER_COUNTER_MULTI_SATURATE_EN.
- Defined: counters saturate at 2^COUNTER_WIDTH-1. Further increments hold the value, including a partial MODE2 add that would cross the maximum.
- Undefined: counters wrap modulo 2^COUNTER_WIDTH.

Test Plan:
- MODE0, CHANNELS=4: ch0 gets 5 handshakes, ch2 gets 3, plus 2 tvalid-only cycles on ch1; snapshot -> 4 beats with tid 0..3, tdata 5,0,3,0, tlast on tid 3, tuser 0.
- Snapshot in the same cycle as a ch0 handshake, with ch0 count=7 -> report tdata[ch0]=7; second snapshot later with no traffic -> tdata[ch0]=1.
- MODE1/MODE2 on ch1: 3 beats with tkeep 0xF, 0x3, 0x1 and tlast on beat 3 -> MODE1 reports 1; MODE2 reports 7.
- tx_tready=0 for 10 cycles during SEND, then a second snapshot -> tdata/tid stable throughout, trigger dropped; the next accepted report has tuser=1 on all beats, the following report has tuser=0.
- COUNTER_WIDTH=4, 18 beats on ch0 -> tdata 15 with SATURATE_EN, 2 without.
- REPORT_PERIOD=16, no snapshot -> reports start at cycles 16, 32, …; areset during beat 2 -> tx_tvalid=0 next cycle, all counters 0.
